// File: rtl/display_pkg.sv
// Shared types, segment codes and the double-dabble step used by the
// count-to-seven-segment display path.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 12;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_code(input logic [3:0] nibble);
    logic [6:0] code;
    if (nibble <= 4'd9) code = SEG_DIGIT[nibble];
    else                code = SEG_BLANK;
    return code;
  endfunction

  // One conversion step: correct every BCD nibble that would overflow, then shift.
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] adj;
    adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (adj[8 + 4*i +: 4] >= 4'd5) adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
    end
    return {adj[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter, one double-dabble step
// per clock; result and done pulse are registered.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk_5MHz,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done,
  output logic             idle
);

  conv_state_e      state_q;
  logic [19:0]      sr_q;
  logic [2:0]       iter_q;
  logic [BCD_W-1:0] bcd_q;
  logic             done_q;

  always_ff @(posedge clk_5MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= 20'd0;
      iter_q  <= 3'd0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q    <= {12'd0, bin};
            iter_q  <= 3'd0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q   <= dabble_step(sr_q);
          iter_q <= iter_q + 3'd1;
          if (iter_q == 3'd7) state_q <= DONE;
        end
        DONE: begin
          bcd_q   <= sr_q[19:8];
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;
  assign idle = (state_q == IDLE);

endmodule

// File: rtl/count_display_driver.sv
// Converts the stopwatch count to BCD and multiplexes it onto a 4-digit
// common-anode seven-segment display (slot 3 is a permanently blank slot).
module count_display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV   = 5000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk_5MHz,
  input  logic                  reset,
  input  logic [7:0]            count,
  output logic [BCD_W-1:0]      bcd,
  output logic                  bcd_valid,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  logic [7:0]            count_q;
  logic [7:0]            src_q;
  logic [RW-1:0]         refresh_q;
  logic [1:0]            digit_q;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  conv_idle;
  logic                  conv_start;
  logic [3:0]            hund, tens, ones;

  // Only the latest captured value is converted; changes during a conversion wait here.
  assign conv_start = conv_idle && (count_q != src_q);

  bin2bcd_seq u_conv (
    .clk_5MHz (clk_5MHz),
    .reset    (reset),
    .start    (conv_start),
    .bin      (count_q),
    .bcd      (bcd),
    .done     (bcd_valid),
    .idle     (conv_idle)
  );

  assign hund = bcd[11:8];
  assign tens = bcd[7:4];
  assign ones = bcd[3:0];

  always_comb begin
    an_d  = 4'hF;
    seg_d = SEG_BLANK;
    case (digit_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = seg_code(ones);
      end
      2'd1: begin
        an_d  = 4'b1101;
        if ((BLANK_LEADING != 0) && (hund == 4'd0) && (tens == 4'd0)) seg_d = SEG_BLANK;
        else                                                            seg_d = seg_code(tens);
      end
      2'd2: begin
        an_d  = 4'b1011;
        if ((BLANK_LEADING != 0) && (hund == 4'd0)) seg_d = SEG_BLANK;
        else                                         seg_d = seg_code(hund);
      end
      default: begin
        an_d  = 4'hF;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk_5MHz or posedge reset) begin
    if (reset) begin
      count_q   <= 8'd0;
      src_q     <= 8'd0;
      refresh_q <= '0;
      digit_q   <= 2'd0;
      seg_q     <= SEG_BLANK;
      an_q      <= 4'hF;
    end else begin
      count_q <= count;
      if (conv_start) src_q <= count_q;
      if (refresh_q == REFRESH_LAST) begin
        refresh_q <= '0;
        digit_q   <= digit_q + 2'd1;
      end else begin
        refresh_q <= refresh_q + RW'(1);
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed and randomized checks of count_display_driver against a decimal
// arithmetic reference, with blanking on and off.
`timescale 1ns/1ps
module tb_count_display_driver;

  logic        clk_5MHz = 1'b0;
  logic        reset;
  logic [7:0]  count;
  logic [11:0] bcd_b, bcd_n;
  logic        v_b, v_n;
  logic [6:0]  seg_b, seg_n;
  logic [3:0]  an_b, an_n;
  logic        dp_b, dp_n;

  int checks = 0;
  int errors = 0;
  int unsigned edges;

  logic [6:0] seg_tab [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  always #100 clk_5MHz = ~clk_5MHz;

  count_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1)) dut_b (
    .clk_5MHz (clk_5MHz), .reset (reset), .count (count),
    .bcd (bcd_b), .bcd_valid (v_b), .seg (seg_b), .an (an_b), .dp (dp_b)
  );

  count_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(0)) dut_n (
    .clk_5MHz (clk_5MHz), .reset (reset), .count (count),
    .bcd (bcd_n), .bcd_valid (v_n), .seg (seg_n), .an (an_n), .dp (dp_n)
  );

  // Clock edges since reset release, used to locate the expected scan slot.
  always @(posedge clk_5MHz or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [10:0] ref_disp(input int v, input int slot, input bit blank);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (slot)
      0:       return {4'b1110, seg_tab[o]};
      1:       return {4'b1101, (blank && h == 0 && t == 0) ? 7'h7F : seg_tab[t]};
      2:       return {4'b1011, (blank && h == 0) ? 7'h7F : seg_tab[h]};
      default: return {4'b1111, 7'h7F};
    endcase
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_bcd"},   {bcd_b, bcd_n}, 24'd0);
    chk({tag, "_valid"}, {v_b, v_n}, 2'b00);
    chk({tag, "_an"},    {an_b, an_n}, 8'hFF);
    chk({tag, "_seg"},   {seg_b, seg_n}, 14'h3FFF);
    chk({tag, "_dp"},    {dp_b, dp_n}, 2'b11);
  endtask

  // Expects count_q to capture v at the next rising edge (E0).
  task automatic expect_conv(input int v, input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_5MHz);
      if (v_b || v_n) pulses++;
    end
    chk({tag, "_early_pulse"}, pulses, 0);
    @(negedge clk_5MHz);
    chk({tag, "_valid"}, {v_b, v_n}, 2'b11);
    chk({tag, "_bcd"}, bcd_b, ref_bcd(v));
    chk({tag, "_bcd_nb"}, bcd_n, ref_bcd(v));
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_5MHz);
      if (v_b || v_n) pulses++;
    end
    chk({tag, "_single_pulse"}, pulses, 0);
  endtask

  task automatic drive_conv(input int v, input string tag);
    @(negedge clk_5MHz);
    count = 8'(v);
    expect_conv(v, tag);
  endtask

  task automatic scan_check(input int v, input int cycles, input string tag);
    int slot;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_5MHz);
      slot = int'(((edges - 1) / 4) % 4);
      chk({tag, "_disp_blank"},  {an_b, seg_b}, ref_disp(v, slot, 1'b1));
      chk({tag, "_disp_noblank"}, {an_n, seg_n}, ref_disp(v, slot, 1'b0));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int prev;
    int v;
    int first_at;
    int second_at;
    logic [11:0] seen [$];

    // Reset with a zero count: no conversion should follow.
    reset = 1'b1;
    count = 8'd0;
    #350;
    chk_reset("rst0");
    @(negedge clk_5MHz);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_5MHz);
      if (v_b || v_n) pulses++;
    end
    chk("zero_no_conv", pulses, 0);
    chk("zero_bcd", bcd_b, 12'h000);

    // Reset held with count = A5, then release.
    @(negedge clk_5MHz);
    reset = 1'b1;
    count = 8'hA5;
    #1;
    chk_reset("rstA5");
    repeat (2) @(negedge clk_5MHz);
    chk_reset("rstA5_hold");
    reset = 1'b0;
    @(posedge clk_5MHz);
    #1;
    chk("first_edge_an", an_b, 4'b1110);
    chk("first_edge_seg", seg_b, 7'b1000000);
    expect_conv(165, "conv165");

    drive_conv(255, "conv255");
    drive_conv(0,   "conv0");
    drive_conv(9,   "conv9");
    drive_conv(10,  "conv10");
    drive_conv(99,  "conv99");
    drive_conv(100, "conv100");

    drive_conv(7, "conv7");
    scan_check(7, 20, "scan7");

    // Count changes 12 -> 200 while the first conversion is shifting.
    @(negedge clk_5MHz);
    count = 8'd12;
    first_at = -1;
    second_at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_5MHz);
      if (v_b) begin
        seen.push_back(bcd_b);
        if (first_at < 0) first_at = i;
        else if (second_at < 0) second_at = i;
      end
      if (i == 2) count = 8'd200;
    end
    chk("mid_pulse_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("mid_first_val", seen[0], 12'h012);
      chk("mid_second_val", seen[1], 12'h200);
    end
    chk("mid_first_at", first_at, 10);
    chk("mid_second_at", second_at, 20);
    chk("mid_final_nb", bcd_n, 12'h200);

    // Reset asserted just after E5 of a conversion of 77.
    @(negedge clk_5MHz);
    count = 8'd77;
    repeat (6) @(posedge clk_5MHz);
    #1;
    reset = 1'b1;
    #1;
    chk_reset("rst_mid");
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_5MHz);
      if (v_b || v_n) pulses++;
    end
    chk("rst_mid_no_pulse", pulses, 0);
    count = 8'd42;
    @(negedge clk_5MHz);
    reset = 1'b0;
    expect_conv(42, "conv42");
    scan_check(42, 16, "scan42");

    // Randomized values, each different from the previous one.
    prev = 42;
    for (int n = 0; n < 6; n++) begin
      v = int'($urandom_range(1, 255));
      if (v == prev) v = (v % 255) + 1;
      drive_conv(v, "rand");
      scan_check(v, 8, "rand_scan");
      prev = v;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
# count_display_driver

Converts the stopwatch's 8-bit binary count into three BCD digits with a sequential double-dabble converter. It then scans them onto the board's 4-digit, common-anode seven-segment display. The block sits directly downstream of the up/down counter core and runs in the same `clk_5MHz` domain. `count` therefore needs no synchronizer.

## Interface
Parameters:
- `REFRESH_DIV`, default 5000: clocks per digit slot; 5 MHz / 5000 gives a 1 kHz slot rate and a 250 Hz frame rate. Legal range ≥ 2.
- `BLANK_LEADING`, default 1: 1 blanks leading zeros; 0 always shows three digits.

Ports:
- `clk_5MHz`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `count`  in  8  binary value from the counter core.
- `bcd`  out  12  {hundreds, tens, ones} of the last completed conversion.
- `bcd_valid`  out  1  one-cycle pulse when `bcd` updates.
- `seg`  out  7  {g,f,e,d,c,b,a}, active-low.
- `an`  out  4  digit anodes, active-low; `an[0]` is the rightmost digit.
- `dp`  out  1  decimal point, active-low; tied to 1 (off).

## Operation
Reset values:
- `bcd`=0, `bcd_valid`=0, `seg`=7'h7F, `an`=4'hF, `dp`=1.
- FSM=IDLE, source register=0, refresh counter=0, digit index=0.

Capture:
- `count` is registered every clock into `count_q`.

Converter FSM (IDLE, SHIFT, DONE):
- IDLE → SHIFT when `count_q` != `src`. On this edge, load `src`←`count_q`, shift register←{12'b0, `count_q`}, and iteration counter←0.
- SHIFT performs one double-dabble step per clock: add 3 to each BCD nibble ≥5, then shift left by 1. It goes to DONE after the 8th step.
- DONE loads `bcd`←shift register[19:8] and pulses `bcd_valid`, then returns to IDLE.
- `count` changes during SHIFT/DONE are not aborted. They are picked up in IDLE by the `count_q` != `src` compare; only the latest value is converted.
- Since `src` resets to 0, a count of 0 after reset triggers no conversion; `bcd` is already 0.

Scan:
- The refresh counter runs 0..`REFRESH_DIV`-1 and wraps.
- At the terminal value, the digit index increments 0→1→2→3→0.
- Index 0 = ones, 1 = tens, 2 = hundreds, 3 = blank slot: `an`=4'hF, `seg`=7'h7F. The blank slot keeps a constant 1/4 duty.

Blanking, when `BLANK_LEADING`=1:
- Hundreds is blank when it is 0.
- Tens is blank when hundreds and tens are both 0.
- Ones is never blank.
- A blanked digit drives `seg`=7'h7F with its anode still active.

Segment codes (`seg`):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Nibbles 10–15 → 7'h7F. This cannot occur and is defensive only.

## Timing
- `count` stable before edge E0 → `count_q` at E0 → SHIFT at E1 → steps at E2..E9 → `bcd` updates at E10.
- `bcd_valid` is high for exactly the one cycle following E10.
- Minimum spacing between conversions is 10 clocks; the upstream count rate is far slower.
- `seg`/`an` are registered from the digit index and `bcd`, with one clock of latency.
- The first clock edge after reset deasserts drives digit 0.
- A `bcd` update appears on `seg` one clock after `bcd` changes.
- Asserting `reset` mid-conversion immediately returns all state to the reset values; the partial result is discarded.
- After reset deasserts, a nonzero `count` starts a fresh conversion per the timeline above.

## Structure
- Package `display_pkg`:
  - FSM state enum (IDLE/SHIFT/DONE).
  - `SEG_DIGIT[0:9]` code constants and `SEG_BLANK`=7'h7F.
  - `NUM_DIGITS`=4 and `BCD_W`=12.
- Sub-module `bin2bcd_seq`: `clk_5MHz`, `reset`, `start`, `bin[7:0]` → `bcd[11:0]`, `done`. It contains the converter FSM.
- The top level holds the capture/compare logic, refresh counter, digit mux, blanking, and segment decode.

## Test plan
- Reset: assert `reset` with `count`=8'hA5 → `bcd`=0, `bcd_valid`=0, `an`=4'hF, `seg`=7'h7F, `dp`=1. Release → no conversion until `count_q` differs from 0; then `bcd`=12'h165 at E10.
- Full scale: `count`=255 → `bcd`=12'h255 with a single `bcd_valid` pulse exactly 10 clocks after the `count_q` edge. Repeat for 0, 9, 10, 99, 100 → 12'h000, 009, 010, 099, 100.
- Blanking with `REFRESH_DIV`=4, `count`=7:
  - slot 0: `an`=1110, `seg`=1111000;
  - slots 1, 2: `an`=1101/1011, `seg`=7'h7F;
  - slot 3: `an`=1111;
  - each slot lasts 4 clocks.
- Blanking off: with `BLANK_LEADING`=0, `count`=7 → tens and hundreds slots show `seg`=1000000.
- Mid-conversion change: `count` 12→200 during SHIFT → `bcd`=12'h012 with a pulse, then a second conversion yields 12'h200 with a second pulse. No other intermediate value appears.
- Reset mid-conversion: assert `reset` at E5 → outputs go to reset values asynchronously and no `bcd_valid` pulse occurs. After release with `count`=42 → `bcd`=12'h042.
